// File: rtl/immediate_generator_pkg.sv
// Shared types for immediate generation and encoding.
// Holds the immediate format selector, the encoder error codes, the bit
// positions of the split immediate fields, and a signed-range helper.
package immediate_generator_pkg;

    // Immediate format selector; codes 3'b110 and 3'b111 are unassigned.
    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_Z = 3'd5
    } imm_src_t;

    typedef enum logic [1:0] {
        IMM_ERR_NONE     = 2'd0,
        IMM_ERR_RANGE    = 2'd1,
        IMM_ERR_MISALIGN = 2'd2,
        IMM_ERR_ILLEGAL  = 2'd3
    } imm_err_t;

    // S-type: imm[11:5] -> [31:25], imm[4:0] -> [11:7]
    localparam int S_HI_MSB = 31;
    localparam int S_HI_LSB = 25;
    localparam int S_LO_MSB = 11;
    localparam int S_LO_LSB = 7;

    // B-type: imm[12] -> [31], imm[10:5] -> [30:25], imm[4:1] -> [11:8], imm[11] -> [7]
    localparam int B_SIGN_POS = 31;
    localparam int B_HI_MSB   = 30;
    localparam int B_HI_LSB   = 25;
    localparam int B_LO_MSB   = 11;
    localparam int B_LO_LSB   = 8;
    localparam int B_B11_POS  = 7;

    // J-type: imm[20] -> [31], imm[10:1] -> [30:21], imm[11] -> [20], imm[19:12] -> [19:12]
    localparam int J_SIGN_POS = 31;
    localparam int J_LO_MSB   = 30;
    localparam int J_LO_LSB   = 21;
    localparam int J_B11_POS  = 20;
    localparam int J_HI_MSB   = 19;
    localparam int J_HI_LSB   = 12;

    // True when v equals the sign extension of v[msb:0].
    function automatic logic fits_signed(input logic [31:0] v, input logic [4:0] msb);
        logic [4:0]  amt;
        logic [31:0] sh;
        amt = 5'd31 - msb;
        sh  = v << amt;
        return (($signed(sh) >>> amt) == $signed(v));
    endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Packs an immediate into the RV32I bit positions of a base instruction.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: base/imm/imm_src in; instr (packed word, or base on error) and err_code out.
module imm_field_pack
    import immediate_generator_pkg::*;
(
    input  logic [31:0] base,
    input  logic [31:0] imm,
    input  logic [2:0]  imm_src,
    output logic [31:0] instr,
    output imm_err_t    err_code
);

    logic [31:0] packed_word;
    logic        illegal;
    logic        aligned;
    logic        in_range;

    always_comb begin
        packed_word = base;
        illegal     = 1'b0;
        aligned     = 1'b1;
        in_range    = 1'b1;
        case (imm_src_t'(imm_src))
            IMM_I: begin
                packed_word[31:20] = imm[11:0];
                in_range           = fits_signed(imm, 5'd11);
            end
            IMM_S: begin
                packed_word[S_HI_MSB:S_HI_LSB] = imm[11:5];
                packed_word[S_LO_MSB:S_LO_LSB] = imm[4:0];
                in_range                       = fits_signed(imm, 5'd11);
            end
            IMM_B: begin
                packed_word[B_SIGN_POS]        = imm[12];
                packed_word[B_HI_MSB:B_HI_LSB] = imm[10:5];
                packed_word[B_LO_MSB:B_LO_LSB] = imm[4:1];
                packed_word[B_B11_POS]         = imm[11];
                in_range                       = fits_signed(imm, 5'd12);
                aligned                        = ~imm[0];
            end
            IMM_U: begin
                packed_word[31:12] = imm[31:12];
                in_range           = (imm[11:0] == 12'd0);
            end
            IMM_J: begin
                packed_word[J_SIGN_POS]        = imm[20];
                packed_word[J_LO_MSB:J_LO_LSB] = imm[10:1];
                packed_word[J_B11_POS]         = imm[11];
                packed_word[J_HI_MSB:J_HI_LSB] = imm[19:12];
                in_range                       = fits_signed(imm, 5'd20);
                aligned                        = ~imm[0];
            end
            IMM_Z: begin
                packed_word[24:20] = imm[4:0];
                in_range           = (imm[31:5] == 27'd0);
            end
            default: illegal = 1'b1;
        endcase
    end

    // Priority: illegal selector, then misalignment, then range.
    always_comb begin
        if (illegal)        err_code = IMM_ERR_ILLEGAL;
        else if (!aligned)  err_code = IMM_ERR_MISALIGN;
        else if (!in_range) err_code = IMM_ERR_RANGE;
        else                err_code = IMM_ERR_NONE;
    end

    // An errored result carries the base word untouched.
    assign instr = (err_code == IMM_ERR_NONE) ? packed_word : base;

endmodule

// File: rtl/imm_instr_encoder.sv
// Encodes an immediate into a base RV32I instruction with range/alignment checks.
// Latency: 2 cycles at out_ready=1, one result per cycle.
// Backpressure: two-entry valid/ready pipeline; in_ready drops when both stages are full.
// Ports: in_valid/in_ready/in_imm_src/in_imm/in_base request side; out_valid/out_ready/
// out_instr/out_err/out_err_code result side; err_count = saturating errored-delivery count.
module imm_instr_encoder
    import immediate_generator_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_imm_src,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [1:0]       out_err_code,
    output logic [CNT_W-1:0] err_count
);

    logic [31:0] pack_instr;
    imm_err_t    pack_code;

    logic        s1_valid;
    logic [31:0] s1_instr;
    imm_err_t    s1_code;
    logic        s2_valid;
    logic [31:0] s2_instr;
    imm_err_t    s2_code;
    logic        adv2;

    imm_field_pack u_pack (
        .base     (in_base),
        .imm      (in_imm),
        .imm_src  (in_imm_src),
        .instr    (pack_instr),
        .err_code (pack_code)
    );

    // Stage 2 can load when empty or draining; stage 1 when empty or moving on.
    assign adv2     = !s2_valid || out_ready;
    assign in_ready = !s1_valid || adv2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_instr <= 32'd0;
            s1_code  <= IMM_ERR_NONE;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_instr <= pack_instr;
                s1_code  <= pack_code;
            end
        end
    end

    // Data only loads with a valid item, so a stalled output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_instr <= 32'd0;
            s2_code  <= IMM_ERR_NONE;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_instr <= s1_instr;
                s2_code  <= s1_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (out_valid && out_ready && out_err && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

    assign out_valid    = s2_valid;
    assign out_instr    = s2_instr;
    assign out_err_code = s2_code;
    assign out_err      = (s2_code != IMM_ERR_NONE);

endmodule
